mod_addsub_pipe: RTL
====================

Name: mod_addsub_pipe

Overview:
- Pipelined, parametrised modular adder/subtractor: computes (A + B) mod M or (A - B) mod M for a run-time-programmable modulus M.
- Keeps the existing datapath: hashed cells and envelope cells feeding a parallel-prefix carry tree with dual carry/result selection, using K = 2^N - M.
- Adds a register-programmable modulus, an add/sub mode, LAT pipeline stages, valid/ready handshaking and a tag passthrough.
- Sits between the operand sequencer and the residue accumulator in the RNS datapath.

Parameters:
- N, 7, operand/modulus width in bits (N >= 2)
- LAT, 2, pipeline latency in cycles, legal 1..4; prefix levels are split across stages as evenly as possible
- TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mod_load  in  1  request to load a new modulus
- mod_in  in  N  modulus value to load
- mod_err  out  1  one-cycle pulse: modulus load rejected
- busy  out  1  high while any pipeline stage holds a valid op
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid & in_ready
- in_sub  in  1  0 = A+B, 1 = A-B
- in_a  in  N  operand A
- in_b  in  N  operand B
- in_tag  in  TAG_W  tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_s  out  N  result
- out_tag  out  TAG_W  tag of this result
- out_err  out  1  operand range error (see Optional Feature)

Behaviour:
- Clock, reset and modulus
  - One clock; reset is asynchronous and active-low (rst_n); all state clears immediately on assertion.
  - Reset values: all stage valids = 0, out_valid = 0, out_s = 0, out_tag = 0, out_err = 0, mod_err = 0, busy = 0.
  - Modulus register resets to M = 2^N - 1 (K = 1).
  - K register holds 2^N - M; it is computed once at load time, never per operation.
- Modulus load
  - A load is accepted only when mod_load = 1, busy = 0, in_valid = 0 and 2 <= mod_in <= 2^N - 1.
  - Accepted: M and K update on that edge; the next accepted op uses the new modulus.
  - Otherwise: M is unchanged and mod_err pulses high for exactly one cycle in the following cycle.
  - mod_load and in_valid high in the same cycle: the operation wins and the load is rejected (mod_err).
- Subtraction
  - Uses B' = M - B mod M; B = 0 gives B' = 0.
  - Then A + B' goes through the same modular-add datapath.
  - The (M - B) pre-step lives in stage 1 and does not add latency.
- Arithmetic
  - Inputs satisfy A, B < M.
  - Result = A + B' if A + B' < M, else A + B' - M.
  - Carry-out selection: cout = carry(A + B' + K) at bit N; result bits are taken from the K-offset sum when cout = 1.
- Pipeline and handshake
  - Global advance enable en = !out_valid | out_ready.
  - in_ready = en, combinational from out_valid and out_ready.
  - Every stage register (data, tag, valid) loads only when en = 1.
  - Latency is exactly LAT cycles from acceptance to out_valid when out_ready stays 1.
  - Throughput is one op per cycle.
  - Stall: out_valid & !out_ready freezes all stages; out_s, out_tag and out_err hold stable; no op is dropped or duplicated.
  - busy = OR of all stage valid bits, including the output stage.
- Reset mid-operation
  - In-flight ops are discarded, with no output for them.
  - The modulus reverts to 2^N - 1.

Optional Feature:
- Macro MODADD_RANGE_CHECK_EN.
- Defined:
  - Stage 1 flags in_a >= M or in_b >= M.
  - The flag travels with the op to out_err.
  - out_s for a flagged op is forced to 0.
- Undefined:
  - out_err is tied 0.
  - Out-of-range operands produce whatever the datapath computes: deterministic, but not a valid residue.

Test Plan:
- Basic add: N=7, LAT=2, load M=69 (K=59), A=21, B=37, add, tag=5 -> out_s=58, out_tag=5 exactly 2 cycles after acceptance.
- Wrap and subtract: M=69, back-to-back ops (50+40, 21-37, 0-0, 68+68) with out_ready=1 -> results 21, 53, 0, 67 on consecutive cycles.
- Backpressure: stream 6 ops, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 6 results in order with correct tags, none lost.
- Modulus load rules:
  - mod_in=1 -> mod_err pulse, M unchanged.
  - Load while busy=1 -> mod_err.
  - Load M=127 when idle -> accepted; 100+50 -> 23.
- Reset mid-flight: assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately, busy=0, M back to 127, no stale output after release.
- Range check, with MODADD_RANGE_CHECK_EN defined: M=69, A=70, B=1 -> out_err=1, out_s=0; without the macro, out_err stays 0.

Source files
------------

// File: rtl/mod_addsub_pipe_if.sv
// Operand/result stream and modulus-control bundle for mod_addsub_pipe.
// The master side drives operands and control; the slave side (the adder) returns results.
interface mod_addsub_pipe_if #(
    parameter int unsigned N     = 7,
    parameter int unsigned TAG_W = 4
);
    logic             mod_load;
    logic [N-1:0]     mod_in;
    logic             mod_err;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_s;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output mod_load, mod_in, in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        input  mod_err, busy, in_ready, out_valid, out_s, out_tag, out_err
    );

    modport slave (
        input  mod_load, mod_in, in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        output mod_err, busy, in_ready, out_valid, out_s, out_tag, out_err
    );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Pipelined modular adder/subtractor with programmable modulus M and K = 2^N - M.
// Optional operand range check enabled by defining MODADD_RANGE_CHECK_EN.
module mod_addsub_pipe #(
    parameter int unsigned N     = 7,
    parameter int unsigned LAT   = 2,
    parameter int unsigned TAG_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    mod_addsub_pipe_if.slave bus
);
    localparam int NLEV = $clog2(N);
    localparam int ILAT = int'(LAT);

    // h*: per-bit half sums kept for the final XOR; g*/p*: prefix state as levels are applied.
    // Tree 0 resolves A + B'; tree 1 resolves A + B' + K after a carry-save envelope.
    typedef struct packed {
        logic             valid;
        logic             err;
        logic [TAG_W-1:0] tag;
        logic             ctop;
        logic [N-1:0]     h0;
        logic [N-1:0]     g0;
        logic [N-1:0]     p0;
        logic [N-1:0]     h1;
        logic [N-1:0]     g1;
        logic [N-1:0]     p1;
    } stage_t;

    function automatic stage_t prefix_level(input stage_t s, input int lvl);
        stage_t r;
        int     d;
        r = s;
        d = 1 << lvl;
        for (int i = 0; i < int'(N); i++) begin
            if (i >= d) begin
                r.g0[i] = s.g0[i] | (s.p0[i] & s.g0[i-d]);
                r.p0[i] = s.p0[i] & s.p0[i-d];
                r.g1[i] = s.g1[i] | (s.p1[i] & s.g1[i-d]);
                r.p1[i] = s.p1[i] & s.p1[i-d];
            end
        end
        return r;
    endfunction

    logic [N-1:0] mod_q, k_q;
    logic         mod_err_q;
    logic         en, busy, load_ok;
    logic [N-1:0] b_neg, b_eff, env_x, env_c, env_y;
    stage_t       pre;
    stage_t       st_d [LAT];
    stage_t       st_q [LAT];
    stage_t       last;
    logic [N-1:0] sum0, sum1, res;
    logic         cout;
    logic         unused_bits;

    assign en      = !st_q[LAT-1].valid || bus.out_ready;
    assign load_ok = bus.mod_load && !busy && !bus.in_valid && (bus.mod_in >= N'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_q     <= '1;
            k_q       <= N'(1);
            mod_err_q <= 1'b0;
        end else begin
            mod_err_q <= bus.mod_load && !load_ok;
            if (load_ok) begin
                mod_q <= bus.mod_in;
                k_q   <= ~bus.mod_in + N'(1);
            end
        end
    end

    // Stage 1 front end: subtrahend negation, hashed cells and the K envelope.
    always_comb begin
        b_neg = (bus.in_b == '0) ? '0 : mod_q - bus.in_b;
        b_eff = bus.in_sub ? b_neg : bus.in_b;
        env_x = bus.in_a ^ b_eff ^ k_q;
        env_c = (bus.in_a & b_eff) | (bus.in_a & k_q) | (b_eff & k_q);
        env_y = {env_c[N-2:0], 1'b0};
        pre       = '0;
        pre.valid = bus.in_valid;
        pre.tag   = bus.in_tag;
        pre.h0    = bus.in_a ^ b_eff;
        pre.p0    = bus.in_a ^ b_eff;
        pre.g0    = bus.in_a & b_eff;
        pre.h1    = env_x ^ env_y;
        pre.p1    = env_x ^ env_y;
        pre.g1    = env_x & env_y;
        pre.ctop  = env_c[N-1];
`ifdef MODADD_RANGE_CHECK_EN
        pre.err   = (bus.in_a >= mod_q) || (bus.in_b >= mod_q);
`endif
    end

    // Stage s applies prefix levels [s*NLEV/LAT, (s+1)*NLEV/LAT) before its register.
    always_comb begin
        for (int s = 0; s < ILAT; s++) begin
            if (s == 0) st_d[s] = pre;
            else        st_d[s] = st_q[(s == 0) ? 0 : s - 1];
            for (int j = 0; j < NLEV; j++) begin
                if (j >= (s * NLEV) / ILAT && j < ((s + 1) * NLEV) / ILAT) begin
                    st_d[s] = prefix_level(st_d[s], j);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < ILAT; s++) st_q[s] <= '0;
        end else if (en) begin
            for (int s = 0; s < ILAT; s++) st_q[s] <= st_d[s];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < ILAT; s++) busy = busy | st_q[s].valid;
    end

    // Final carry resolution and K-offset selection on the output register.
    assign last = st_q[LAT-1];
    assign sum0 = last.h0 ^ {last.g0[N-2:0], 1'b0};
    assign sum1 = last.h1 ^ {last.g1[N-2:0], 1'b0};
    assign cout = last.ctop | last.g1[N-1];
    assign res  = cout ? sum1 : sum0;

    assign bus.in_ready  = en;
    assign bus.busy      = busy;
    assign bus.mod_err   = mod_err_q;
    assign bus.out_valid = last.valid;
    assign bus.out_tag   = last.tag;
`ifdef MODADD_RANGE_CHECK_EN
    assign bus.out_s     = last.err ? '0 : res;
    assign bus.out_err   = last.err;
`else
    assign bus.out_s     = res;
    assign bus.out_err   = 1'b0;
`endif

    assign unused_bits = ^{last.p0, last.p1, last.err, last.g0[N-1]};
endmodule
